// File: rtl/cipher_pkg.sv
// Shared widths and types for the cipher input path: block geometry, block tags
// and the packer state encoding.
package cipher_pkg;

    localparam int unsigned DATA_LENGTH = 128;
    localparam int unsigned LENGTH      = 32;
    localparam int unsigned WORDS       = DATA_LENGTH / LENGTH;
    localparam int unsigned BLOCK_BYTES = DATA_LENGTH / 8;
    localparam int unsigned WORD_BYTES  = LENGTH / 8;

    typedef enum logic [1:0] {BLK_KEY, BLK_AD, BLK_MSG} blk_type_t;

    typedef logic [DATA_LENGTH-1:0] block_t;

    typedef enum logic {pk_fill, pk_hold} pack_state_t;

endpackage

// File: rtl/cipher_pad_mask.sv
// Final-block shaping: on a last block, zeroes every byte from i_nbytes onward
// and places the 0x80 pad marker at byte i_nbytes (none when the block is full).
module cipher_pad_mask
    import cipher_pkg::*;
(
    input  block_t     i_blk,
    input  logic [4:0] i_nbytes,
    input  logic       i_last,
    output block_t     o_blk
);

    always_comb begin
        o_blk = i_blk;
        if (i_last) begin
            // Byte 0 sits in the most significant byte of the block.
            for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
                if (i == 32'(i_nbytes)) begin
                    o_blk[DATA_LENGTH-1-8*i -: 8] = 8'h80;
                end else if (i > 32'(i_nbytes)) begin
                    o_blk[DATA_LENGTH-1-8*i -: 8] = '0;
                end
            end
        end
    end

endmodule

// File: rtl/cipher_block_packer.sv
// Packs 32-bit host words into tagged 128-bit blocks for the cipher I/O controller,
// tracking valid bytes, the stream-final block and sticky protocol errors.
module cipher_block_packer
    import cipher_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LENGTH-1:0]      in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_type,
    input  logic                   in_last,
    input  logic [2:0]             in_bytes,
    output logic [DATA_LENGTH-1:0] blk_data,
    output logic                   blk_valid,
    input  logic                   blk_ready,
    output logic [1:0]             blk_type,
    output logic                   blk_last,
    output logic [4:0]             blk_nbytes,
    output logic                   err
);

    pack_state_t r_state;
    logic [1:0]  r_word_cnt;
    logic [4:0]  r_byte_cnt;
    block_t      r_blk;
    blk_type_t   r_type;
    logic        r_in_ready;
    logic        r_blk_valid;
    logic        r_blk_last;
    logic [4:0]  r_nbytes;
    logic        r_err;

    logic [2:0]        w_bytes;
    logic [LENGTH-1:0] w_word;
    block_t            w_acc;
    block_t            w_padded;
    logic [4:0]        w_byte_sum;
    logic              w_proto_err;
    logic              w_accept;
    logic              w_complete;

    always_comb begin
        // Out-of-range byte counts are treated as a full word and flagged below.
        w_bytes = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
        w_word  = in_data;
        for (int unsigned j = 0; j < WORD_BYTES; j++) begin
            if (j >= 32'(w_bytes)) begin
                w_word[LENGTH-1-8*j -: 8] = '0;
            end
        end
        w_acc = r_blk;
        for (int unsigned k = 0; k < WORDS; k++) begin
            if (k == 32'(r_word_cnt)) begin
                w_acc[DATA_LENGTH-1-LENGTH*k -: LENGTH] = w_word;
            end
        end
        w_byte_sum  = r_byte_cnt + {2'b00, w_bytes};
        w_proto_err = (!in_last && (w_bytes != 3'd4)) ||
                      (in_bytes > 3'd4) ||
                      (in_type == 2'd3) ||
                      ((r_word_cnt != 2'd0) && (in_type != r_type));
        w_accept    = in_valid && r_in_ready;
        w_complete  = (r_word_cnt == 2'(WORDS-1)) || in_last;
    end

    cipher_pad_mask u_pad (
        .i_blk    (w_acc),
        .i_nbytes (w_byte_sum),
        .i_last   (in_last),
        .o_blk    (w_padded)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= pk_fill;
            r_word_cnt  <= '0;
            r_byte_cnt  <= '0;
            r_blk       <= '0;
            r_type      <= BLK_KEY;
            r_in_ready  <= 1'b1;
            r_blk_valid <= 1'b0;
            r_blk_last  <= 1'b0;
            r_nbytes    <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                pk_fill: begin
                    if (w_accept) begin
                        if (w_proto_err) begin
                            r_err <= 1'b1;
                        end
                        if (r_word_cnt == 2'd0) begin
                            r_type <= blk_type_t'(in_type);
                        end
                        if (w_complete) begin
                            r_blk       <= w_padded;
                            r_state     <= pk_hold;
                            r_in_ready  <= 1'b0;
                            r_blk_valid <= 1'b1;
                            r_blk_last  <= in_last;
                            r_nbytes    <= w_byte_sum;
                        end else begin
                            r_blk      <= w_acc;
                            r_word_cnt <= r_word_cnt + 2'd1;
                            r_byte_cnt <= w_byte_sum;
                        end
                    end
                end
                pk_hold: begin
                    // The block register doubles as the accumulator, so it is cleared on release.
                    if (blk_ready) begin
                        r_state     <= pk_fill;
                        r_in_ready  <= 1'b1;
                        r_blk_valid <= 1'b0;
                        r_blk_last  <= 1'b0;
                        r_nbytes    <= '0;
                        r_blk       <= '0;
                        r_word_cnt  <= '0;
                        r_byte_cnt  <= '0;
                    end
                end
                default: r_state <= pk_fill;
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign blk_data   = r_blk;
    assign blk_valid  = r_blk_valid;
    assign blk_type   = r_type;
    assign blk_last   = r_blk_last;
    assign blk_nbytes = r_nbytes;
    assign err        = r_err;

endmodule
